pzc_gap_scheduler: RTL and testbench

- Orbit-synchronous controller that sequences the pedestal/PZC tracker.
- Tracks the bunch-crossing (BC) position from the orbit marker `bc0` and locks to the orbit.
- Generates `bt_mask_out`, which is 0 during the long gap, and a correction-window qualifier.
- Sits between the timing interface and the per-channel PZC/pedestal trackers, and is shared by all channels of one board.
- Gap position, gap length and guard are run-time configurable; writes are shadowed and applied at an orbit boundary.

---
 rtl/pzc_gap_scheduler.sv | 148 ++++++++++++++
 tb/tb_pzc_gap_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pzc_gap_scheduler.sv
// Orbit-synchronous gap scheduler: locks to bc0, decodes the long gap into a
// bunch-train mask and a tracker correction window, with orbit-aligned config.
module pzc_gap_scheduler #(
  parameter int unsigned ORBIT_LEN     = 3564,
  parameter int unsigned BCW           = 12,
  parameter int unsigned GAP_START_DEF = 3443,
  parameter int unsigned GAP_LEN_DEF   = 121,
  parameter int unsigned GUARD_DEF     = 8,
  parameter int unsigned BT_NUM        = 16,
  parameter int unsigned LOCK_CNT      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bc0,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_addr,
  input  logic [BCW-1:0] cfg_wdata,
  output logic           bt_mask_out,
  output logic           corr_window,
  output logic [BCW-1:0] bc_count,
  output logic           locked,
  output logic           orbit_err,
  output logic [15:0]    gap_count
);

  localparam int unsigned GCW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;

  state_t         state, state_nxt;
  logic [GCW-1:0] good_cnt, good_nxt;
  logic [BCW-1:0] bc_nxt;
  logic           err_nxt;
  logic           at_end;
  logic           copy;
  logic           in_gap;
  logic [BCW-1:0] off;
  logic [BCW:0]   off_guard;
  logic [BCW-1:0] sh_start, sh_len, sh_guard;
  logic [BCW-1:0] sh_start_nxt, sh_len_nxt, sh_guard_nxt;
  logic [BCW-1:0] act_start, act_len, act_guard;
  logic [BCW-1:0] act_start_nxt, act_len_nxt, act_guard_nxt;

  // Modular distance from gap start; the 12-bit wrap of the intermediate sum is harmless.
  function automatic logic [BCW-1:0] gap_off(input logic [BCW-1:0] bc,
                                             input logic [BCW-1:0] start);
    if (bc >= start) return bc - start;
    else             return bc - start + BCW'(ORBIT_LEN);
  endfunction

  function automatic logic gap_hit(input logic [BCW-1:0] bc,
                                   input logic [BCW-1:0] start,
                                   input logic [BCW-1:0] len);
    return (len != '0) && (gap_off(bc, start) < len);
  endfunction

  assign at_end    = (bc_count == BCW'(ORBIT_LEN - 1));
  assign locked    = (state == LOCKED);
  assign off       = gap_off(bc_count, act_start);
  assign off_guard = {1'b0, off} + {1'b0, act_guard};
  assign in_gap    = locked && gap_hit(bc_count, act_start, act_len);

  assign bt_mask_out = ~in_gap;
  assign corr_window = in_gap && (off >= BCW'(BT_NUM)) && (off_guard < {1'b0, act_len});

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    bc_nxt    = (bc0 || at_end) ? '0 : bc_count + 1'b1;
    case (state)
      UNLOCKED: begin
        if (bc0) begin
          state_nxt = SYNCING;
          good_nxt  = '0;
        end
      end
      SYNCING: begin
        if (bc0 && at_end) begin
          good_nxt = good_cnt + 1'b1;
          if (good_cnt == GCW'(LOCK_CNT - 1)) state_nxt = LOCKED;
        end else if (bc0 || at_end) begin
          good_nxt = '0;
          err_nxt  = 1'b1;
        end
      end
      LOCKED: begin
        if (bc0 != at_end) begin
          state_nxt = SYNCING;
          good_nxt  = '0;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    sh_start_nxt = sh_start;
    sh_len_nxt   = sh_len;
    sh_guard_nxt = sh_guard;
    if (cfg_we && (cfg_wdata < BCW'(ORBIT_LEN))) begin
      case (cfg_addr)
        2'd0:    sh_start_nxt = cfg_wdata;
        2'd1:    sh_len_nxt   = cfg_wdata;
        2'd2:    sh_guard_nxt = cfg_wdata;
        default: ;
      endcase
    end
    // Shadow-next feeds active so a write on the orbit boundary lands immediately.
    copy          = (state == UNLOCKED) || bc0 || at_end;
    act_start_nxt = copy ? sh_start_nxt : act_start;
    act_len_nxt   = copy ? sh_len_nxt   : act_len;
    act_guard_nxt = copy ? sh_guard_nxt : act_guard;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCKED;
      bc_count  <= '0;
      good_cnt  <= '0;
      orbit_err <= 1'b0;
      gap_count <= '0;
      sh_start  <= BCW'(GAP_START_DEF);
      sh_len    <= BCW'(GAP_LEN_DEF);
      sh_guard  <= BCW'(GUARD_DEF);
      act_start <= BCW'(GAP_START_DEF);
      act_len   <= BCW'(GAP_LEN_DEF);
      act_guard <= BCW'(GUARD_DEF);
    end else begin
      state     <= state_nxt;
      bc_count  <= bc_nxt;
      good_cnt  <= good_nxt;
      orbit_err <= err_nxt;
      sh_start  <= sh_start_nxt;
      sh_len    <= sh_len_nxt;
      sh_guard  <= sh_guard_nxt;
      act_start <= act_start_nxt;
      act_len   <= act_len_nxt;
      act_guard <= act_guard_nxt;
      // Count a gap only when it ends with the scheduler still locked on the next cycle.
      if (in_gap && (state_nxt == LOCKED) &&
          !gap_hit(bc_nxt, act_start_nxt, act_len_nxt) && (gap_count != 16'hFFFF))
        gap_count <= gap_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pzc_gap_scheduler.sv
// Directed self-checking bench for pzc_gap_scheduler: lock, gap decode,
// bc0 faults, wrapping config and asynchronous reset.
module tb_pzc_gap_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bc0 = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic        bt_mask_out, corr_window, locked, orbit_err;
  logic [11:0] bc_count;
  logic [15:0] gap_count;

  int total = 0;
  int bad = 0;
  int exp_bc = 0;
  int err_seen = 0;

  pzc_gap_scheduler #(.ORBIT_LEN(3564), .BCW(12)) dut (
    .clk(clk), .rst(rst), .bc0(bc0), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .bt_mask_out(bt_mask_out), .corr_window(corr_window),
    .bc_count(bc_count), .locked(locked), .orbit_err(orbit_err), .gap_count(gap_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic b0);
    bc0 = b0;
    @(posedge clk);
    #1;
    bc0 = 1'b0;
    cfg_we = 1'b0;
    if (b0 || exp_bc == 3563) exp_bc = 0;
    else exp_bc = exp_bc + 1;
    if (orbit_err) err_seen = err_seen + 1;
  endtask

  task automatic run_to(input int target);
    while (exp_bc != target) step(1'b0);
  endtask

  task automatic relock(input int n);
    repeat (n) begin
      run_to(3563);
      step(1'b1);
    end
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [11:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step(1'b0);
  endtask

  task automatic test_reset;
    #2;
    total++; if (bt_mask_out !== 1'b1) begin bad++; $display("FAIL reset_mask got=%b exp=1", bt_mask_out); end
    total++; if (corr_window !== 1'b0) begin bad++; $display("FAIL reset_corr got=%b exp=0", corr_window); end
    total++; if (bc_count !== 12'd0) begin bad++; $display("FAIL reset_bc got=%0d exp=0", bc_count); end
    total++; if ({locked, orbit_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {locked, orbit_err}); end
    total++; if (gap_count !== 16'd0) begin bad++; $display("FAIL reset_gapcnt got=%0d exp=0", gap_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_bc = 0;
    step(1'b0);
    total++; if (bc_count !== 12'd1) begin bad++; $display("FAIL count_start got=%0d exp=1", bc_count); end
  endtask

  task automatic test_lock;
    err_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      run_to(3563);
      step(1'b1);
      if (i == 4) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_5th got=%b exp=1", locked); end
    total++; if (bc_count !== 12'd0) begin bad++; $display("FAIL lock_bc got=%0d exp=0", bc_count); end
    total++; if (err_seen !== 0) begin bad++; $display("FAIL lock_noerr got=%0d exp=0", err_seen); end
  endtask

  task automatic test_gap_timing;
    int mism = 0;
    int first = -1;
    logic em, ec;
    do begin
      em = !(exp_bc >= 3443 && exp_bc <= 3563);
      ec = (exp_bc >= 3459 && exp_bc <= 3555);
      if (bt_mask_out !== em || corr_window !== ec || bc_count !== 12'(exp_bc)) begin
        mism++;
        if (first < 0) first = exp_bc;
      end
      step(exp_bc == 3563);
    end while (exp_bc != 0);
    total++; if (mism !== 0) begin bad++; $display("FAIL default_gap got=%0d bad cycles (first bc %0d) exp=0", mism, first); end
    total++; if (gap_count !== 16'd1) begin bad++; $display("FAIL gap_count_inc got=%0d exp=1", gap_count); end
    total++; if (err_seen !== 0) begin bad++; $display("FAIL gap_noerr got=%0d exp=0", err_seen); end
  endtask

  task automatic test_early_bc0;
    run_to(100);
    step(1'b1);
    total++; if (orbit_err !== 1'b1) begin bad++; $display("FAIL early_err got=%b exp=1", orbit_err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL early_unlock got=%b exp=0", locked); end
    total++; if (bc_count !== 12'd0) begin bad++; $display("FAIL early_bc got=%0d exp=0", bc_count); end
    step(1'b0);
    total++; if (orbit_err !== 1'b0) begin bad++; $display("FAIL early_pulse got=%b exp=0", orbit_err); end
    relock(3);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL early_relock3 got=%b exp=0", locked); end
    relock(1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL early_relock4 got=%b exp=1", locked); end
  endtask

  task automatic test_missed_bc0;
    run_to(3563);
    total++; if (bt_mask_out !== 1'b0) begin bad++; $display("FAIL missed_pre_mask got=%b exp=0", bt_mask_out); end
    step(1'b0);
    total++; if (orbit_err !== 1'b1) begin bad++; $display("FAIL missed_err got=%b exp=1", orbit_err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL missed_unlock got=%b exp=0", locked); end
    total++; if (bc_count !== 12'd0) begin bad++; $display("FAIL missed_wrap got=%0d exp=0", bc_count); end
    total++; if ({bt_mask_out, corr_window} !== 2'b10) begin bad++; $display("FAIL missed_mask got=%b exp=10", {bt_mask_out, corr_window}); end
    total++; if (gap_count !== 16'd1) begin bad++; $display("FAIL missed_gapcnt got=%0d exp=1", gap_count); end
    relock(4);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL missed_relock got=%b exp=1", locked); end
  endtask

  task automatic test_wrap_cfg;
    int mism = 0;
    int first = -1;
    logic em, ec;
    run_to(1000);
    write_cfg(2'd0, 12'd3500);
    write_cfg(2'd1, 12'd200);
    write_cfg(2'd1, 12'd4000);
    do begin
      em = !(exp_bc >= 3443 && exp_bc <= 3563);
      ec = (exp_bc >= 3459 && exp_bc <= 3555);
      if (bt_mask_out !== em || corr_window !== ec) begin
        mism++;
        if (first < 0) first = exp_bc;
      end
      step(exp_bc == 3563);
    end while (exp_bc != 0);
    total++; if (mism !== 0) begin bad++; $display("FAIL wrap_cur_orbit got=%0d bad cycles (first bc %0d) exp=0", mism, first); end
    total++; if (gap_count !== 16'd1) begin bad++; $display("FAIL wrap_gap_continues got=%0d exp=1", gap_count); end
    mism = 0;
    first = -1;
    do begin
      em = !(exp_bc >= 3500 || exp_bc <= 135);
      ec = (exp_bc >= 3516 || exp_bc <= 127);
      if (bt_mask_out !== em || corr_window !== ec) begin
        mism++;
        if (first < 0) first = exp_bc;
      end
      if (exp_bc == 136) begin
        total++; if (gap_count !== 16'd2) begin bad++; $display("FAIL wrap_gapcnt got=%0d exp=2", gap_count); end
      end
      step(exp_bc == 3563);
    end while (exp_bc != 0);
    total++; if (mism !== 0) begin bad++; $display("FAIL wrap_next_orbit got=%0d bad cycles (first bc %0d) exp=0", mism, first); end
  endtask

  task automatic test_async_reset;
    run_to(3500);
    total++; if (bt_mask_out !== 1'b0) begin bad++; $display("FAIL rst_pre_mask got=%b exp=0", bt_mask_out); end
    rst = 1'b1;
    #1;
    total++; if ({bt_mask_out, corr_window} !== 2'b10) begin bad++; $display("FAIL rst_mid_outputs got=%b exp=10", {bt_mask_out, corr_window}); end
    total++; if (gap_count !== 16'd0) begin bad++; $display("FAIL rst_mid_gapcnt got=%0d exp=0", gap_count); end
    total++; if ({locked, bc_count} !== 13'd0) begin bad++; $display("FAIL rst_mid_state got=%0h exp=0", {locked, bc_count}); end
    @(negedge clk);
    rst = 1'b0;
    exp_bc = 0;
    relock(5);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rst_relock got=%b exp=1", locked); end
    run_to(3443);
    total++; if ({bt_mask_out, corr_window} !== 2'b00) begin bad++; $display("FAIL rst_default_cfg got=%b exp=00", {bt_mask_out, corr_window}); end
    run_to(3459);
    total++; if (corr_window !== 1'b1) begin bad++; $display("FAIL rst_default_corr got=%b exp=1", corr_window); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_gap_timing;
    test_early_bc0;
    test_missed_bc0;
    test_wrap_cfg;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
